audio_ps2_synth: RTL and testbench

//  PS/2 keyboard-driven square-wave tone generator for the audio codec path.
//  - Receives PS/2 scancodes and shows the last valid byte on two 7-segment digits.
//  - Plays a fixed note while a mapped key is held.
//  - Streams signed 16-bit samples to the codec interface with a periodic write strobe.

---
 rtl/audio_ps2_synth.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_audio_ps2_synth.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_ps2_synth.sv
`timescale 1ns/1ps
// ============================================================================
// audio_ps2_synth
//
// PS/2 keyboard-driven square-wave tone generator for the audio codec path.
// A PS/2 receiver decodes scancodes. The last valid byte is shown on two
// 7-segment digits. While a mapped key is held, a fixed note plays as a
// signed 16-bit square wave. Samples go to the codec with a periodic strobe.
//
// Ports:
//   CLOCK_50     in   1   system clock; all logic on its rising edge
//   KEY          in   4   KEY[0] = asynchronous active-low reset; KEY[3:1] unused
//   ps2_clock    in   1   PS/2 clock from keyboard (asynchronous)
//   ps2_data     in   1   PS/2 data from keyboard (asynchronous)
//   HEX0         out  7   low nibble of last byte, active-low, bit6=g .. bit0=a
//   HEX1         out  7   high nibble of last byte, same encoding
//   square_wave  out  16  signed sample: +AMPLITUDE, -AMPLITUDE or 0
//   wr           out  1   one-cycle sample-write strobe every SAMPLE_DIV clocks
//
// Build option:
//   AUDIO_PS2_PARITY_CHECK_EN  when defined, frames without odd parity are
//                              dropped; otherwise the parity bit is ignored.
// ============================================================================
module audio_ps2_synth #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SAMPLE_DIV  = 1042,
    parameter logic [15:0] AMPLITUDE   = 16'h2000,
    parameter int unsigned PS2_TIMEOUT = 25000
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic        ps2_clock,
    input  logic        ps2_data,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [15:0] square_wave,
    output logic        wr
);

    // The lowest note (262 Hz) has the longest half-period.
    localparam int unsigned TW = $clog2(CLK_HZ / 524 + 1);
    localparam int unsigned SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned PW = (PS2_TIMEOUT > 1) ? $clog2(PS2_TIMEOUT) : 1;

    // Key FSM: waiting for a make code, or a break prefix (F0) has been seen.
    localparam logic [0:0] KS_MAKE  = 1'b0;
    localparam logic [0:0] KS_BREAK = 1'b1;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXTENDED = 8'hE0;

    logic w_rst_n;
    logic w_unused_keys;

    assign w_rst_n       = KEY[0];
    assign w_unused_keys = ^KEY[3:1];

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [TW-1:0] half_of(input int unsigned hz);
        return TW'(CLK_HZ / (2 * hz));
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // PS/2 input synchronisers and falling-edge detect
    // ------------------------------------------------------------------------
    logic r_ps2c_meta, r_ps2c_sync, r_ps2c_prev;
    logic r_ps2d_meta, r_ps2d_sync;
    logic w_fall;

    // Idle-high reset values so leaving reset never fakes a falling edge.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ps2c_meta <= 1'b1;
            r_ps2c_sync <= 1'b1;
            r_ps2c_prev <= 1'b1;
            r_ps2d_meta <= 1'b1;
            r_ps2d_sync <= 1'b1;
        end else begin
            r_ps2c_meta <= ps2_clock;
            r_ps2c_sync <= r_ps2c_meta;
            r_ps2c_prev <= r_ps2c_sync;
            r_ps2d_meta <= ps2_data;
            r_ps2d_sync <= r_ps2d_meta;
        end
    end

    assign w_fall = r_ps2c_prev & ~r_ps2c_sync;

    // ------------------------------------------------------------------------
    // Frame receiver: start, d0..d7, parity, stop; LSB first
    // ------------------------------------------------------------------------
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic [PW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_byte_stb;
    logic [10:0]   w_frame;
    logic          w_parity_ok;
    logic          w_frame_ok;

    // The first bit shifted in has reached bit 0 by the 11th edge, so the
    // frame is the first ten bits plus the one being sampled now.
    assign w_frame = {r_ps2d_sync, r_shift};

`ifdef AUDIO_PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^w_frame[9:1];
`else
    logic w_unused_parity;
    assign w_unused_parity = w_frame[9];
    assign w_parity_ok     = 1'b1;
`endif

    assign w_frame_ok = ~w_frame[0] & w_frame[10] & w_parity_ok;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_to_cnt   <= '0;
            r_byte     <= '0;
            r_byte_stb <= 1'b0;
        end else begin
            r_byte_stb <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        r_byte     <= w_frame[8:1];
                        r_byte_stb <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {r_ps2d_sync, r_shift[9:1]};
                end
            end else if (r_bit_cnt != 4'd0) begin
                // A stalled partial frame is abandoned so the next start bit
                // lines up with bit 0 again.
                if (r_to_cnt == PW'(PS2_TIMEOUT - 1)) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + PW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scancode to note half-period map
    // ------------------------------------------------------------------------
    logic          w_map_hit;
    logic [TW-1:0] w_map_half;

    always_comb begin
        w_map_hit  = 1'b1;
        w_map_half = '0;
        case (r_byte)
            8'h15: w_map_half = half_of(262);
            8'h1D: w_map_half = half_of(294);
            8'h24: w_map_half = half_of(330);
            8'h2D: w_map_half = half_of(349);
            8'h2C: w_map_half = half_of(392);
            8'h35: w_map_half = half_of(440);
            8'h3C: w_map_half = half_of(494);
            8'h43: w_map_half = half_of(523);
            8'h44: w_map_half = half_of(587);
            8'h4D: w_map_half = half_of(659);
            8'h54: w_map_half = half_of(698);
            8'h5B: w_map_half = half_of(784);
            default: w_map_hit = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Key FSM, display byte and tone generator
    // ------------------------------------------------------------------------
    logic [0:0]    r_key_st;
    logic [7:0]    r_last;
    logic          r_active;
    logic [7:0]    r_note_key;
    logic [TW-1:0] r_half;
    logic [TW-1:0] r_tone_cnt;
    logic          r_phase;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_st   <= KS_MAKE;
            r_last     <= '0;
            r_active   <= 1'b0;
            r_note_key <= '0;
            r_half     <= '0;
            r_tone_cnt <= '0;
            r_phase    <= 1'b0;
        end else begin
            if (r_active) begin
                if (r_tone_cnt == r_half - TW'(1)) begin
                    r_tone_cnt <= '0;
                    r_phase    <= ~r_phase;
                end else begin
                    r_tone_cnt <= r_tone_cnt + TW'(1);
                end
            end else begin
                r_tone_cnt <= '0;
                r_phase    <= 1'b0;
            end

            // Byte handling comes last so a note start overrides the tone
            // counter update above.
            if (r_byte_stb) begin
                r_last <= r_byte;
                if (r_byte == SC_BREAK) begin
                    r_key_st <= KS_BREAK;
                end else if (r_byte == SC_EXTENDED) begin
                    r_key_st <= r_key_st;
                end else if (r_key_st == KS_BREAK) begin
                    r_key_st <= KS_MAKE;
                    if (r_active && (r_byte == r_note_key)) begin
                        r_active <= 1'b0;
                    end
                end else if (w_map_hit && !(r_active && (r_byte == r_note_key))) begin
                    // Typematic repeats of the sounding key fall outside
                    // this branch, so the waveform is not restarted.
                    r_active   <= 1'b1;
                    r_note_key <= r_byte;
                    r_half     <= w_map_half;
                    r_tone_cnt <= '0;
                    r_phase    <= 1'b0;
                end
            end
        end
    end

    assign HEX0 = seg7(r_last[3:0]);
    assign HEX1 = seg7(r_last[7:4]);

    // ------------------------------------------------------------------------
    // Sample clock and registered sample
    // ------------------------------------------------------------------------
    logic [SW-1:0] r_smp_cnt;
    logic          r_wr;
    logic [15:0]   r_sample;
    logic [15:0]   w_neg_amp;
    logic [15:0]   w_next_sample;

    assign w_neg_amp     = 16'd0 - AMPLITUDE;
    assign w_next_sample = r_active ? (r_phase ? w_neg_amp : AMPLITUDE) : 16'd0;

    // The sample only moves together with wr, so the codec sees a value that
    // is stable for the whole strobe period.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_smp_cnt <= '0;
            r_wr      <= 1'b0;
            r_sample  <= '0;
        end else if (r_smp_cnt == SW'(SAMPLE_DIV - 1)) begin
            r_smp_cnt <= '0;
            r_wr      <= 1'b1;
            r_sample  <= w_next_sample;
        end else begin
            r_smp_cnt <= r_smp_cnt + SW'(1);
            r_wr      <= 1'b0;
        end
    end

    assign square_wave = r_sample;
    assign wr          = r_wr;

endmodule

// File: tb/tb_audio_ps2_synth.sv
`timescale 1ns/1ps
// ============================================================================
// tb_audio_ps2_synth
//
// Drives PS/2 frames into audio_ps2_synth (scaled-down clock parameters so
// notes toggle within a few hundred cycles) and compares HEX digits, the wr
// strobe and every held sample against a timeline model of the keyboard and
// note state.
// ============================================================================
module tb_audio_ps2_synth;

    localparam int          CLK_HZ  = 200_000;
    localparam int          SD      = 37;
    localparam int          TO      = 300;
    localparam int          HP      = 8;
    localparam logic [15:0] AMP     = 16'h2000;
    localparam logic [15:0] NEG_AMP = 16'hE000;

    logic        CLOCK_50 = 1'b0;
    logic [3:0]  KEY      = 4'b1111;
    logic        ps2_clock = 1'b1;
    logic        ps2_data  = 1'b1;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [15:0] square_wave;
    logic        wr;

    audio_ps2_synth #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_DIV  (SD),
        .AMPLITUDE   (AMP),
        .PS2_TIMEOUT (TO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .KEY         (KEY),
        .ps2_clock   (ps2_clock),
        .ps2_data    (ps2_data),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .square_wave (square_wave),
        .wr          (wr)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int note_code [12] = '{'h15, 'h1D, 'h24, 'h2D, 'h2C, 'h35, 'h3C, 'h43, 'h44, 'h4D, 'h54, 'h5B};
    int note_hz   [12] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784};

    // Cycles since reset release, counted on rising edges.
    int cyc = 0;
    always @(posedge CLOCK_50) if (KEY[0]) cyc++;

    // Note state before (o_) and from (n_) cycle eff onwards.
    int         o_act, o_half, o_start;
    int         n_act, n_half, n_start;
    int         eff;
    int         m_brk;
    logic [7:0] m_key;
    logic [7:0] m_last;
    logic [15:0] held;
    bit          held_ok;

    function automatic int half_for(input logic [7:0] b);
        for (int i = 0; i < 12; i++)
            if (note_code[i] == int'(b)) return CLK_HZ / (2 * note_hz[i]);
        return 0;
    endfunction

    task automatic model_reset();
        o_act = 0; o_half = 0; o_start = 0;
        n_act = 0; n_half = 0; n_start = 0;
        eff = 0; m_brk = 0; m_key = 8'h00; m_last = 8'h00;
        cyc = 0; held = 16'h0000; held_ok = 1'b1;
    endtask

    // Valid byte b takes effect on the note state from cycle s.
    task automatic model_apply(input logic [7:0] b, input int s);
        int h;
        o_act = n_act; o_half = n_half; o_start = n_start;
        m_last = b;
        if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_brk = m_brk;
        end else if (m_brk != 0) begin
            m_brk = 0;
            if (n_act != 0 && b == m_key) n_act = 0;
        end else begin
            h = half_for(b);
            if (h > 0 && !(n_act != 0 && b == m_key)) begin
                n_act = 1; n_half = h; n_start = s; m_key = b;
            end
        end
        eff = s;
    endtask

    // Sample the tone would produce from the state at cycle t; amb flags a
    // cycle sitting right at a state change or phase toggle.
    function automatic logic [15:0] exp_sample(input int t, output bit amb);
        int act, half, st, d;
        amb = (t >= eff - 1) && (t <= eff + 1);
        if (t >= eff) begin act = n_act; half = n_half; st = n_start; end
        else          begin act = o_act; half = o_half; st = o_start; end
        if (act == 0) return 16'h0000;
        d = t - st;
        if (d < 0) begin amb = 1'b1; return 16'h0000; end
        if ((d % half) == 0 || (d % half) == half - 1) amb = 1'b1;
        return (((d / half) % 2) == 1) ? NEG_AMP : AMP;
    endfunction

    // ------------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------------
    always @(negedge CLOCK_50) begin : mon
        logic [15:0] e;
        bit          amb;
        bit          ew;
        #1;
        if (!KEY[0]) begin
            check("rst_wr", {31'd0, wr}, 32'd0);
            check("rst_square", {16'd0, square_wave}, 32'd0);
        end else begin
            ew = (cyc > 0) && ((cyc % SD) == 0);
            check("wr", {31'd0, wr}, {31'd0, ew});
            if (ew) begin
                e = exp_sample(cyc - 1, amb);
                held = e;
                held_ok = !amb;
            end
            if (held_ok) check("sample", {16'd0, square_wave}, {16'd0, held});
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic check_hex(input string tag);
        check({tag, "_hex0"}, {25'd0, HEX0}, {25'd0, glyph[m_last[3:0]]});
        check({tag, "_hex1"}, {25'd0, HEX1}, {25'd0, glyph[m_last[7:4]]});
    endtask

    // Sends the first nbits of a frame; a full valid frame updates the model
    // at the instant of its last falling edge.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        bit          ok;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = (~^b) ^ bad_par;
        f[10]   = ~bad_stop;
`ifdef AUDIO_PS2_PARITY_CHECK_EN
        ok = !bad_par && !bad_stop;
`else
        ok = !bad_stop;
`endif
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            ps2_data = f[i];
            repeat (HP) @(negedge CLOCK_50);
            ps2_clock = 1'b0;
            if (i == 10 && ok) model_apply(b, cyc + 4);
            repeat (HP) @(negedge CLOCK_50);
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HP) @(negedge CLOCK_50);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
        check_hex("byte");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input int hold);
        #3 KEY[0] = 1'b0;
        model_reset();
        #1;
        check("reset_hex0", {25'd0, HEX0}, 32'h40);
        check("reset_hex1", {25'd0, HEX1}, 32'h40);
        check("reset_square", {16'd0, square_wave}, 32'd0);
        check("reset_wr", {31'd0, wr}, 32'd0);
        repeat (hold) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
    endtask

    function automatic logic [7:0] rand_unmapped();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (half_for(b) != 0 || b == 8'hF0 || b == 8'hE0);
        return b;
    endfunction

    initial begin
        logic [7:0] k;
        int         sel;

        model_reset();
        @(negedge CLOCK_50);
        do_reset(4);
        idle(3 * SD + 5);

        // Directed sequences
        send_byte(8'h15);                 idle(900);
        send_byte(8'h15);                 idle(300);
        send_byte(8'hF0); send_byte(8'h15); idle(200);
        send_byte(8'h35);                 idle(500);
        send_byte(8'hAB);                 idle(300);
        send_byte(8'hF0); send_byte(8'hAB); idle(300);
        send_byte(8'hF0); send_byte(8'h35); idle(200);
        send_byte(8'h1D);                 idle(400);
        send_byte(8'hF0); send_byte(8'h1D); idle(200);
        send_byte(8'h1D);                 idle(400);
        send_frame(8'h4D, 1'b1, 1'b0, 11); check_hex("badpar"); idle(400);
        send_frame(8'h5B, 1'b0, 1'b1, 11); check_hex("badstop"); idle(100);
        send_frame(8'h24, 1'b0, 1'b0, 4);  idle(TO + 50);
        send_byte(8'h2C);                 idle(400);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h2C); idle(200);

        // Reset in the middle of a note and of a frame
        send_byte(8'h43); idle(250);
        do_reset(6); idle(2 * SD);
        send_frame(8'h44, 1'b0, 1'b0, 5);
        do_reset(3); idle(SD);
        send_byte(8'h44); idle(300);

        // Randomized traffic
        for (int it = 0; it < 45; it++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: send_byte(8'(note_code[$urandom_range(0, 11)]));
                4: begin
                    if (n_act != 0 && $urandom_range(0, 3) != 0) k = m_key;
                    else k = 8'(note_code[$urandom_range(0, 11)]);
                    send_byte(8'hF0);
                    send_byte(k);
                end
                5: send_byte(rand_unmapped());
                6: send_byte(8'hE0);
                7: begin
                    send_frame(8'(note_code[$urandom_range(0, 11)]), 1'b1, 1'b0, 11);
                    check_hex("rand_badpar");
                end
                8: begin
                    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 11);
                    check_hex("rand_badstop");
                end
                default: begin
                    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, $urandom_range(1, 9));
                    idle(TO + 20);
                end
            endcase
            idle($urandom_range(0, 400));
        end

        idle(2 * SD);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
